// File: rtl/exp_compare_swap.sv
// Exponent compare-and-swap front end for an IEEE-754 single-precision adder.
// Optional special-case flags are built only when ESC_SPECIAL_EN is defined.
module exp_compare_swap (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] sig_big,
    output logic [22:0] sig_small,
    output logic [7:0]  exp_big,
    output logic [7:0]  shift,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swapped,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
);

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned SIG_W     = 23;
    localparam int unsigned MAX_SHIFT = 25;

    // Stage 1 holds the unpacked operands and the magnitude-compare result.
    logic             s1_valid;
    logic             s1_sign1, s1_sign2;
    logic [EXP_W-1:0] s1_exp1, s1_exp2;
    logic [SIG_W-1:0] s1_sig1, s1_sig2;
    logic             s1_op2_big;

    logic             s2_adv, s1_adv, in_fire;
    logic             op2_big_c;
    logic [EXP_W-1:0] exp_small_c, exp_big_c, diff_c, shift_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = !reset && s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Exponent field 0 compares as 0; subnormals are not normalised.
    always_comb begin
        op2_big_c = 1'b0;
        if (op2[30:23] > op1[30:23])
            op2_big_c = 1'b1;
        else if (op2[30:23] == op1[30:23] && op2[22:0] > op1[22:0])
            op2_big_c = 1'b1;
    end

    always_comb begin
        exp_big_c   = s1_op2_big ? s1_exp2 : s1_exp1;
        exp_small_c = s1_op2_big ? s1_exp1 : s1_exp2;
        diff_c      = exp_big_c - exp_small_c;
        shift_c     = (diff_c > EXP_W'(MAX_SHIFT)) ? EXP_W'(MAX_SHIFT) : diff_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sign1   <= 1'b0;
            s1_sign2   <= 1'b0;
            s1_exp1    <= '0;
            s1_exp2    <= '0;
            s1_sig1    <= '0;
            s1_sig2    <= '0;
            s1_op2_big <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_sign1   <= op1[31];
                s1_sign2   <= op2[31];
                s1_exp1    <= op1[30:23];
                s1_exp2    <= op2[30:23];
                s1_sig1    <= op1[22:0];
                s1_sig2    <= op2[22:0];
                s1_op2_big <= op2_big_c;
            end
        end
    end

    // Stage 2 presents the ordered operands and the clamped alignment shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            sig_big    <= '0;
            sig_small  <= '0;
            exp_big    <= '0;
            shift      <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sig_big    <= s1_op2_big ? s1_sig2 : s1_sig1;
                sig_small  <= s1_op2_big ? s1_sig1 : s1_sig2;
                exp_big    <= exp_big_c;
                shift      <= shift_c;
                sign_big   <= s1_op2_big ? s1_sign2 : s1_sign1;
                sign_small <= s1_op2_big ? s1_sign1 : s1_sign2;
                swapped    <= s1_op2_big;
            end
        end
    end

`ifdef ESC_SPECIAL_EN
    logic s1_nan, s1_inf, s1_zero;
    logic nan_c, inf_c, zero_c;

    always_comb begin
        nan_c  = (op1[30:23] == 8'hFF && op1[22:0] != '0) ||
                 (op2[30:23] == 8'hFF && op2[22:0] != '0);
        inf_c  = !nan_c && ((op1[30:23] == 8'hFF) || (op2[30:23] == 8'hFF));
        zero_c = (op1[30:0] == '0) && (op2[30:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
            is_nan  <= 1'b0;
            is_inf  <= 1'b0;
            is_zero <= 1'b0;
        end else begin
            if (s1_adv && in_fire) begin
                s1_nan  <= nan_c;
                s1_inf  <= inf_c;
                s1_zero <= zero_c;
            end
            if (s2_adv && s1_valid) begin
                is_nan  <= s1_nan;
                is_inf  <= s1_inf;
                is_zero <= s1_zero;
            end
        end
    end
`else
    assign is_nan  = 1'b0;
    assign is_inf  = 1'b0;
    assign is_zero = 1'b0;
`endif

endmodule

// File: tb/tb_exp_compare_swap.sv
// Scoreboard bench for exp_compare_swap: directed vectors, latency, backpressure
// and mid-flight reset. Flag expectations follow ESC_SPECIAL_EN.
module tb_exp_compare_swap;

`ifdef ESC_SPECIAL_EN
    localparam bit SPECIAL = 1'b1;
`else
    localparam bit SPECIAL = 1'b0;
`endif
    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op1, op2;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [22:0] sig_big, sig_small;
    logic [7:0]  exp_big, shift;
    logic        sign_big, sign_small, swapped, is_nan, is_inf, is_zero;

    exp_compare_swap dut (
        .clk(clk), .reset(reset), .op1(op1), .op2(op2),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .sig_big(sig_big), .sig_small(sig_small),
        .exp_big(exp_big), .shift(shift),
        .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped),
        .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero)
    );

    always #5 clk = ~clk;

    logic [67:0] obs;
    assign obs = {swapped, sign_big, sign_small, exp_big, shift, sig_big, sig_small,
                  is_nan, is_inf, is_zero};

    int n_checks = 0;
    int n_pass   = 0;
    logic [67:0] sb[$];
    logic [31:0] v_op1 [NV];
    logic [31:0] v_op2 [NV];
    logic [67:0] v_exp [NV];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [67:0] mk(input bit sw, input bit sb_, input bit ss,
                                       input logic [7:0] eb, input logic [7:0] sh,
                                       input logic [22:0] sgb, input logic [22:0] sgs,
                                       input bit n, input bit i, input bit z);
        logic [2:0] fl;
        fl = {n, i, z} & {3{SPECIAL}};
        return {sw, sb_, ss, eb, sh, sgb, sgs, fl};
    endfunction

    task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [67:0] e);
        v_op1[k] = a;
        v_op2[k] = b;
        v_exp[k] = e;
    endtask

    // Present vector k, wait (bounded) for acceptance, record its expectation.
    task automatic send(input int k, input bit strict);
        bit ok;
        ok = 1'b0;
        op1 = v_op1[k];
        op2 = v_op2[k];
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (strict && c == 0) check("in_ready_streaming", 96'(in_ready), 96'd1);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 96'(in_ready), 96'd1);
        else sb.push_back(v_exp[k]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pop on every output transfer; check outputs hold during stalls.
    bit          prev_stall = 1'b0;
    logic [67:0] prev_obs;
    logic [67:0] e_pop;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {27'd0, out_valid, obs}, {27'd0, 1'b1, prev_obs});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_output", 96'(sb.size()), 96'd1);
                else begin
                    e_pop = sb.pop_front();
                    check("out_data", 96'(obs), 96'(e_pop));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
        end
    end

    int seen;

    initial begin
        set_vec(0,  32'h40400000, 32'h3F800000, mk(0,0,0,8'd128,8'd1, 23'h400000,23'h0,0,0,0));
        set_vec(1,  32'h3F800000, 32'h41200000, mk(1,0,0,8'd130,8'd3, 23'h200000,23'h0,0,0,0));
        set_vec(2,  32'h3F800000, 32'h3FC00000, mk(1,0,0,8'd127,8'd0, 23'h400000,23'h0,0,0,0));
        set_vec(3,  32'h4B000000, 32'h3F800000, mk(0,0,0,8'd150,8'd23,23'h0,     23'h0,0,0,0));
        set_vec(4,  32'h7F000000, 32'h3F800000, mk(0,0,0,8'd254,8'd25,23'h0,     23'h0,0,0,0));
        set_vec(5,  32'h3F800000, 32'h3F800000, mk(0,0,0,8'd127,8'd0, 23'h0,     23'h0,0,0,0));
        set_vec(6,  32'hC0400000, 32'h3F800000, mk(0,1,0,8'd128,8'd1, 23'h400000,23'h0,0,0,0));
        set_vec(7,  32'h4C000000, 32'h3F800000, mk(0,0,0,8'd152,8'd25,23'h0,     23'h0,0,0,0));
        set_vec(8,  32'h4C800000, 32'h3F800000, mk(0,0,0,8'd153,8'd25,23'h0,     23'h0,0,0,0));
        set_vec(9,  32'h00000001, 32'h00000000, mk(0,0,0,8'd0,  8'd0, 23'h1,     23'h0,0,0,0));
        set_vec(10, 32'h00000000, 32'h00000000, mk(0,0,0,8'd0,  8'd0, 23'h0,     23'h0,0,0,1));
        set_vec(11, 32'h7FC00000, 32'h3F800000, mk(0,0,0,8'd255,8'd25,23'h400000,23'h0,1,0,0));
        set_vec(12, 32'h7F800000, 32'h3F800000, mk(0,0,0,8'd255,8'd25,23'h0,     23'h0,0,1,0));
        set_vec(13, 32'h3F800000, 32'hBFC00000, mk(1,1,0,8'd127,8'd0, 23'h400000,23'h0,0,0,0));
        set_vec(14, 32'h7F800000, 32'h7FC00000, mk(1,0,0,8'd255,8'd0, 23'h400000,23'h0,1,0,0));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 96'(out_valid), 96'd0);
        check("reset_in_ready",  96'(in_ready),  96'd0);
        check("reset_outputs",   96'(obs),       96'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 96'(in_ready), 96'd1);

        // Two-cycle latency on an isolated op.
        @(posedge clk); #1;
        send(0, 1'b1);
        @(negedge clk);
        check("latency_cycle1", 96'(out_valid), 96'd0);
        @(negedge clk);
        check("latency_cycle2", 96'(out_valid), 96'd1);

        // Back-to-back stream with no backpressure.
        @(posedge clk); #1;
        for (int k = 1; k < NV; k++) send(k, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two ops fill the pipe, the third must be refused.
        out_ready = 1'b0;
        send(3, 1'b1);
        send(4, 1'b1);
        op1 = v_op1[6]; op2 = v_op2[6]; in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_full", 96'(in_ready), 96'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset with two ops in flight: both are discarded.
        out_ready = 1'b0;
        send(1, 1'b1);
        send(2, 1'b1);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", 96'(in_ready), 96'd0);
        @(negedge clk);
        check("flush_out_valid", 96'(out_valid), 96'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_post_flush", 96'(in_ready), 96'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("flushed_ops_absent", 96'(seen), 96'd0);

        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 96'(sb.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
